// File: rtl/branch_resolve_unit.sv
// In-flight branch queue: out-of-order resolution, in-order predictor training, mispredict flush.
// Optional BRU_PERF_CNT_EN adds saturating retire/mispredict counters as extra ports.
module branch_resolve_unit #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned GHR_W = 4,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [31:0]      pred_pc,
  input  logic             pred_taken,
  input  logic [GHR_W-1:0] pred_ghr,
  output logic [TAG_W-1:0] pred_tag,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_index,
  output logic             upd_taken,
  output logic [GHR_W-1:0] upd_ghr,
  output logic             flush,
  output logic [31:0]      redirect_pc,
`ifdef BRU_PERF_CNT_EN
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_mispredicts,
`endif
  output logic [TAG_W:0]   count
);

  typedef logic [TAG_W:0] ptr_t;

  ptr_t             head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] valid_q, valid_d, resolved_q, resolved_d, act_q, act_d, ptkn_q;
  logic [31:0]      pc_q  [DEPTH];
  logic [GHR_W-1:0] ghr_q [DEPTH];

  logic             upd_valid_q, upd_taken_q, flush_q;
  logic [IDX_W-1:0] upd_index_q;
  logic [GHR_W-1:0] upd_ghr_q;
  logic [31:0]      redirect_q, redirect_d;

  logic [TAG_W-1:0] head_idx, tail_idx, res_off;
  ptr_t             res_ptr;
  logic             full, res_hit, mispredict, push, retire;
  logic [DEPTH-1:0] younger;

  assign head_idx   = head_q[TAG_W-1:0];
  assign tail_idx   = tail_q[TAG_W-1:0];
  assign full       = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
  assign count      = tail_q - head_q;
  assign res_hit    = res_valid && valid_q[res_tag];
  assign mispredict = res_hit && (res_taken != ptkn_q[res_tag]);
  assign pred_ready = !full && !flush_q && !mispredict;
  assign pred_tag   = tail_idx;
  assign push       = pred_valid && pred_ready;
  assign retire     = valid_q[head_idx] && resolved_q[head_idx];
  assign redirect_d = res_taken ? res_target : pc_q[res_tag] + 32'd4;

  // Age of the resolved entry relative to head rebuilds its full pointer, wrap bit included.
  assign res_off = res_tag - head_idx;
  assign res_ptr = head_q + ptr_t'(res_off);

  always_comb begin
    younger = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      younger[i] = TAG_W'(TAG_W'(i) - head_idx) > res_off;
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    valid_d    = valid_q;
    resolved_d = resolved_q;
    act_d      = act_q;
    if (res_hit) begin
      resolved_d[res_tag] = 1'b1;
      act_d[res_tag]      = res_taken;
    end
    if (retire) begin
      valid_d[head_idx] = 1'b0;
      head_d            = head_q + ptr_t'(1);
    end
    if (mispredict) begin
      tail_d  = res_ptr + ptr_t'(1);
      valid_d = valid_d & ~younger;
    end else if (push) begin
      valid_d[tail_idx]    = 1'b1;
      resolved_d[tail_idx] = 1'b0;
      tail_d               = tail_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      valid_q     <= '0;
      resolved_q  <= '0;
      act_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_index_q <= '0;
      upd_taken_q <= 1'b0;
      upd_ghr_q   <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      resolved_q  <= resolved_d;
      act_q       <= act_d;
      upd_valid_q <= retire;
      if (retire) begin
        upd_index_q <= pc_q[head_idx][IDX_W-1:0];
        upd_taken_q <= act_q[head_idx];
        upd_ghr_q   <= ghr_q[head_idx];
      end
      flush_q <= mispredict;
      if (mispredict) begin
        redirect_q <= redirect_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptkn_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        ghr_q[i] <= '0;
      end
    end else if (push) begin
      ptkn_q[tail_idx] <= pred_taken;
      pc_q[tail_idx]   <= pred_pc;
      ghr_q[tail_idx]  <= pred_ghr;
    end
  end

  assign upd_valid   = upd_valid_q;
  assign upd_index   = upd_index_q;
  assign upd_taken   = upd_taken_q;
  assign upd_ghr     = upd_ghr_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_mp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (retire && (perf_br_q != '1)) begin
        perf_br_q <= perf_br_q + 32'd1;
      end
      if (mispredict && (perf_mp_q != '1)) begin
        perf_mp_q <= perf_mp_q + 32'd1;
      end
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;
`endif

endmodule
